misr_compactor: RTL and testbench



---
 rtl/misr_compactor.sv | 119 +++++++++++
 tb/tb_misr_compactor.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/misr_compactor.sv
// Multiple-input signature register: folds LEN enabled samples of D into SIG,
// then holds the result in DONE and flags PASS when it equals GOLD.
module misr_compactor #(
    parameter int unsigned    W    = 8,
    parameter int unsigned    LEN  = 4,
    parameter logic [W-1:0]   POLY = 8'h1D,
    parameter logic [W-1:0]   SEED = 8'h00
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic         EN,
    input  logic [W-1:0] D,
    input  logic [W-1:0] GOLD,
    output logic [W-1:0] SIG,
    output logic         BUSY,
    output logic         DONE,
    output logic         PASS
);

    localparam int unsigned   CW   = $clog2(LEN + 1);
    localparam int unsigned   SW   = 3;
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    // One-hot state codes.
    localparam logic [SW-1:0] S_IDLE = 3'b001;
    localparam logic [SW-1:0] S_RUN  = 3'b010;
    localparam logic [SW-1:0] S_DONE = 3'b100;

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_nxt;
    logic [SW-1:0] state_d;

    logic [W-1:0]  sig_q;
    logic [W-1:0]  sig_nxt;
    logic [W-1:0]  sig_d;
    logic [W-1:0]  sig_fb;
    logic [W-1:0]  sig_step;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_d;

    logic          last_sample;

    // Flops have no reset pin: RST_N forces the reset value onto every D input.
    assign state_d = (state_nxt & {SW{RST_N}}) | (S_IDLE & {SW{~RST_N}});
    assign sig_d   = (sig_nxt & {W{RST_N}}) | (SEED & {W{~RST_N}});
    assign cnt_d   = cnt_nxt & {CW{RST_N}};

    // State register.
    always_ff @(posedge CLK) begin
        state_q <= state_d;
    end

    // Datapath registers.
    always_ff @(posedge CLK) begin
        sig_q <= sig_d;
        cnt_q <= cnt_d;
    end

    // One MISR step: shift, fold in the polynomial when the MSB falls out, xor D.
    assign sig_fb      = POLY & {W{sig_q[W-1]}};
    assign sig_step    = {sig_q[W-2:0], 1'b0} ^ sig_fb ^ D;
    assign last_sample = EN & (cnt_q == LAST);

    // Next-state logic; any non-one-hot encoding recovers to IDLE.
    always_comb begin
        state_nxt = S_IDLE;
        case (state_q)
            S_IDLE:  state_nxt = START ? S_RUN : S_IDLE;
            S_RUN:   state_nxt = last_sample ? S_DONE : S_RUN;
            S_DONE:  state_nxt = START ? S_RUN : S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Signature and sample counter updates.
    always_comb begin
        sig_nxt = sig_q;
        cnt_nxt = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    sig_nxt = SEED;
                    cnt_nxt = '0;
                end
            end
            S_RUN: begin
                if (EN) begin
                    sig_nxt = sig_step;
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            default: begin
                sig_nxt = sig_q;
                cnt_nxt = cnt_q;
            end
        endcase
    end

    // Status decode from the state flops.
    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state_q)
            S_RUN:   BUSY = 1'b1;
            S_DONE:  DONE = 1'b1;
            default: begin
                BUSY = 1'b0;
                DONE = 1'b0;
            end
        endcase
    end

    assign SIG  = sig_q;
    assign PASS = DONE & (sig_q == GOLD);

endmodule

// File: tb/tb_misr_compactor.sv
// Directed bench for misr_compactor: expected post-edge outputs are queued as
// each step is driven and checked one edge later.
module tb_misr_compactor;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         en;
    logic [W-1:0] d;
    logic [W-1:0] gold;
    logic [W-1:0] sig;
    logic         busy;
    logic         done;
    logic         pass;

    int n_tests;
    int n_fail;

    typedef struct {
        string        tag;
        logic [W-1:0] sig;
        logic         busy;
        logic         done;
        logic         pass;
    } exp_t;

    exp_t sb_q[$];

    misr_compactor #(
        .W    (8),
        .LEN  (4),
        .POLY (8'h1D),
        .SEED (8'h00)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .START (start),
        .EN    (en),
        .D     (d),
        .GOLD  (gold),
        .SIG   (sig),
        .BUSY  (busy),
        .DONE  (done),
        .PASS  (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string fld,
                       input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
            $error("%s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard empty observed=%h expected=none", sig);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, "sig",  sig,            e.sig);
            chk(e.tag, "busy", W'(busy),       W'(e.busy));
            chk(e.tag, "done", W'(done),       W'(e.done));
            chk(e.tag, "pass", W'(pass),       W'(e.pass));
            chk(e.tag, "excl", W'(busy & done), W'(1'b0));
        end
    endtask

    // Drive one cycle of stimulus, queue what the outputs must be after the edge.
    task automatic step(input string tag, input logic r, input logic s, input logic e,
                        input logic [W-1:0] di, input logic [W-1:0] g,
                        input logic [W-1:0] x_sig, input logic x_busy,
                        input logic x_done, input logic x_pass);
        exp_t x;
        rst_n = r;
        start = s;
        en    = e;
        d     = di;
        gold  = g;
        x.tag  = tag;
        x.sig  = x_sig;
        x.busy = x_busy;
        x.done = x_done;
        x.pass = x_pass;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        start = 1'b0;
        en    = 1'b0;
        d     = '0;
        gold  = '0;
        #1;

        // Reset wins over START/EN; PASS stays low although SIG==GOLD.
        step("rst0", 1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        step("rst1", 1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        step("idle_en", 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Shift run; START with EN in IDLE does not compress D.
        step("sh_start", 1'b1, 1'b1, 1'b1, 8'hFF, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0);
        step("sh1", 1'b1, 1'b0, 1'b1, 8'h01, 8'h08, 8'h01, 1'b1, 1'b0, 1'b0);
        step("sh2", 1'b1, 1'b0, 1'b1, 8'h00, 8'h08, 8'h02, 1'b1, 1'b0, 1'b0);
        step("sh3", 1'b1, 1'b0, 1'b1, 8'h00, 8'h08, 8'h04, 1'b1, 1'b0, 1'b0);
        step("sh4", 1'b1, 1'b0, 1'b1, 8'h00, 8'h08, 8'h08, 1'b0, 1'b1, 1'b1);
        step("sh_gold09", 1'b1, 1'b0, 1'b1, 8'hFF, 8'h09, 8'h08, 1'b0, 1'b1, 1'b0);
        step("sh_gold08", 1'b1, 1'b0, 1'b0, 8'h00, 8'h08, 8'h08, 1'b0, 1'b1, 1'b1);

        // Feedback run, started back-to-back from DONE.
        step("fb_start", 1'b1, 1'b1, 1'b0, 8'h00, 8'h74, 8'h00, 1'b1, 1'b0, 1'b0);
        step("fb1", 1'b1, 1'b0, 1'b1, 8'h80, 8'h74, 8'h80, 1'b1, 1'b0, 1'b0);
        step("fb2", 1'b1, 1'b0, 1'b1, 8'h00, 8'h74, 8'h1D, 1'b1, 1'b0, 1'b0);
        step("fb3", 1'b1, 1'b0, 1'b1, 8'h00, 8'h74, 8'h3A, 1'b1, 1'b0, 1'b0);
        step("fb4", 1'b1, 1'b0, 1'b1, 8'h00, 8'h74, 8'h74, 1'b0, 1'b1, 1'b1);
        step("fb_hold", 1'b1, 1'b0, 1'b1, 8'h55, 8'h74, 8'h74, 1'b0, 1'b1, 1'b1);

        // Restart from DONE(74), then EN gaps with a START pulse mid-run.
        step("gap_start", 1'b1, 1'b1, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        step("gap1", 1'b1, 1'b0, 1'b1, 8'h01, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0);
        step("gap2", 1'b1, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0);
        step("gap3_st", 1'b1, 1'b1, 1'b0, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0);
        step("gap4", 1'b1, 1'b0, 1'b1, 8'h01, 8'h0F, 8'h03, 1'b1, 1'b0, 1'b0);
        step("gap5", 1'b1, 1'b0, 1'b0, 8'hFF, 8'h0F, 8'h03, 1'b1, 1'b0, 1'b0);
        step("gap6", 1'b1, 1'b0, 1'b1, 8'h01, 8'h0F, 8'h07, 1'b1, 1'b0, 1'b0);
        step("gap7", 1'b1, 1'b0, 1'b1, 8'h01, 8'h0F, 8'h0F, 1'b0, 1'b1, 1'b1);

        // Abort with reset after the second sample.
        step("ab_start", 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        step("ab1", 1'b1, 1'b0, 1'b1, 8'h80, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0);
        step("ab2", 1'b1, 1'b0, 1'b1, 8'h80, 8'h00, 8'h9D, 1'b1, 1'b0, 1'b0);
        step("ab_rst", 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        step("ab_idle1", 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        step("ab_idle2", 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        n_tests++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $display("FAIL sb_drain observed=%0d expected=0", sb_q.size());
            $error("sb_drain observed=%0d expected=0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
